memory_stage: RTL

Pipeline MEM stage for the 5-stage RISC-V core: consumes the EX/MEM register outputs (ALU result, store data, destination register, control bits) and performs the data-memory access over a req/ack bus. It stalls the front of the pipeline while an access is outstanding, aborts on timeout, and holds the MEM/WB pipeline register feeding writeback and forwarding. Misaligned-access and bus-error flags are sticky, and a saturating stall-cycle counter is provided.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/memory_stage_if.sv | 31 +++
 rtl/mem_wait_timer.sv | 45 ++++
 rtl/memory_stage.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core pipeline stages.
//   mem_state_e      : MEM-stage bus FSM encoding (IDLE=0, WAIT=1)
//   DEFAULT_TIMEOUT  : default bus timeout in request cycles
//   RESULT_SRC_*     : ResultSrc encoding (0 = ALU result, 1 = load data)
//   isMisaligned()   : word-access alignment check for memory ops
// ---------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  localparam logic RESULT_SRC_ALU = 1'b0;
  localparam logic RESULT_SRC_MEM = 1'b1;

  // Only word accesses exist in this core, so any non-zero low address bit
  // on a load or store is misaligned.
  function automatic logic isMisaligned(input logic memOp, input logic [1:0] lowBits);
    return memOp & (lowBits != 2'b00);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// ---------------------------------------------------------------------------
// memory_stage_if
// Data-memory req/ack bus between the MEM stage and the data memory.
//   mem_req   : access request (held until mem_ack or timeout)
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data
//   mem_ack   : access complete; may assert in the request's first cycle
//   mem_rdata : load data, valid while mem_ack = 1
// master = pipeline side, slave = memory side.
// ---------------------------------------------------------------------------
interface memory_stage_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for a bus acknowledge and flags a timeout.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : load the count with 1 (first request cycle has already passed)
//   enable   : advance the count by one
//   inWait   : FSM is in WAIT
//   ack      : bus acknowledge this cycle
//   tmo      : request cycle number TIMEOUT reached without an acknowledge
// ---------------------------------------------------------------------------
module mem_wait_timer
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic inWait,
  input  logic ack,
  output logic tmo
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CW'(1);
    end else if (enable && (cnt != CW'(TIMEOUT))) begin
      // Capped so a request stuck past the timeout cannot wrap the count.
      cnt <= cnt + CW'(1);
    end
  end

  // While in WAIT, cnt equals (request cycle number - 1).
  assign tmo = inWait & ~ack & (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
// MEM stage of the 5-stage RISC-V pipeline. Issues data-memory accesses over
// a req/ack bus, stalls upstream while an access is outstanding, aborts on
// timeout and holds the MEM/WB pipeline register.
//   clk, rst         : clock, asynchronous active-low reset
//   memBus (master)  : data-memory req/ack bus
//   ALU_Result_M     : effective address / ALU result from EX/MEM
//   WriteDataM       : store data
//   PCPlus4M         : link value
//   RD_M             : destination register
//   RegWriteM, MemWriteM, ResultSrcM : control (ResultSrcM=1 means load)
//   StallM           : upstream stages must hold while 1
//   *_W              : MEM/WB register outputs
//   ResultW          : writeback/forwarding value
//   BusErr           : sticky, set on bus timeout
//   MisalignErr      : sticky, set when a misaligned load/store retires
//   StallCount       : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module memory_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  memory_stage_if.master    memBus,
  input  logic [31:0]       ALU_Result_M,
  input  logic [31:0]       WriteDataM,
  input  logic [31:0]       PCPlus4M,
  input  logic [4:0]        RD_M,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  output logic              StallM,
  output logic [31:0]       ALU_Result_W,
  output logic [31:0]       ReadDataW,
  output logic [31:0]       PCPlus4W,
  output logic [4:0]        RD_W,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [31:0]       ResultW,
  output logic              BusErr,
  output logic              MisalignErr,
  output logic [CNT_W-1:0]  StallCount
);

  mem_state_e state;
  mem_state_e stateNext;

  logic memOp;
  logic misal;
  logic memReq;
  logic ack;
  logic tmo;
  logic timerClear;
  logic timerEnable;

  // -------------------------------------------------------------------------
  // Request generation
  // -------------------------------------------------------------------------
  assign memOp = MemWriteM | ResultSrcM;
  assign misal = isMisaligned(memOp, ALU_Result_M[1:0]);
  // rst is folded in so the request drops the instant reset asserts, even
  // mid-access; the memory is expected to tolerate the withdrawal.
  assign memReq = memOp & ~misal & rst;
  assign ack    = memBus.mem_ack;

  assign memBus.mem_req   = memReq;
  assign memBus.mem_we    = MemWriteM;
  assign memBus.mem_addr  = ALU_Result_M;
  assign memBus.mem_wdata = WriteDataM;

  // A timed-out access stops stalling in its final cycle so the instruction
  // retires (as a bubble) on that edge.
  assign StallM = memReq & ~ack & ~tmo;

  // -------------------------------------------------------------------------
  // Bus FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    stateNext   = state;
    timerClear  = 1'b0;
    timerEnable = 1'b0;
    case (state)
      IDLE: begin
        if (memReq && !ack) begin
          stateNext  = WAIT;
          timerClear = 1'b1;
        end
      end
      WAIT: begin
        timerEnable = ~ack;
        if (ack || tmo) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timerClear),
    .enable (timerEnable),
    .inWait (state == WAIT),
    .ack    (ack),
    .tmo    (tmo)
  );

  // -------------------------------------------------------------------------
  // MEM/WB pipeline register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALU_Result_W <= '0;
      ReadDataW    <= '0;
      PCPlus4W     <= '0;
      RD_W         <= '0;
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 1'b0;
    end else if (!StallM) begin
      ALU_Result_W <= ALU_Result_M;
      PCPlus4W     <= PCPlus4M;
      RD_W         <= RD_M;
      ResultSrcW   <= ResultSrcM;
      // Misaligned and timed-out instructions retire without a register write.
      RegWriteW    <= RegWriteM & ~misal & ~tmo;
      ReadDataW    <= (ResultSrcM & ack) ? memBus.mem_rdata : 32'h0;
    end else begin
      // Stalled: push a bubble into writeback, keep the data fields.
      RegWriteW    <= 1'b0;
    end
  end

  assign ResultW = (ResultSrcW == RESULT_SRC_MEM) ? ReadDataW : ALU_Result_W;

  // -------------------------------------------------------------------------
  // Sticky error flags and stall statistics
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BusErr      <= 1'b0;
      MisalignErr <= 1'b0;
      StallCount  <= '0;
    end else begin
      if (tmo) begin
        BusErr <= 1'b1;
      end
      if (misal && !StallM) begin
        MisalignErr <= 1'b1;
      end
      if (StallM && (StallCount != '1)) begin
        StallCount <= StallCount + CNT_W'(1);
      end
    end
  end

endmodule
